// File: rtl/fetch_unit_pkg.sv
// Shared state encoding and default sizing for the instruction-fetch sequencer.
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    FETCH_IDLE = 3'd0,
    FETCH_ADDR = 3'd1,
    FETCH_WAIT = 3'd2,
    FETCH_HOLD = 3'd3,
    FETCH_ERR  = 3'd4
  } fetch_state_e;

  localparam int FETCH_ADDR_W_DEF  = 9;
  localparam int FETCH_TIMEOUT_DEF = 16;

endpackage

// File: rtl/fetch_unit_timer.sv
// Memory-wait timer: cleared on request issue, counts stalled cycles, flags TIMEOUT-1.
module fetch_unit_timer
  import fetch_unit_pkg::*;
#(
  parameter int TIMEOUT = FETCH_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: reads the PC, fetches one word, holds it in IR until
// the control unit acknowledges, and pulses pc_inc once per successful fetch.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W_DEF,
  parameter int TIMEOUT = FETCH_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  input  logic [31:0]       pc_in,
  output logic              pc_inc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ready,
  input  logic [31:0]       mem_data,
  output logic [31:0]       ir_out,
  output logic              ir_valid,
  input  logic              ir_ack,
  output logic              busy,
  output logic              fetch_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [31:0]       ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              pc_inc_q, pc_inc_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              tmr_clear;
  logic              tmr_en;
  logic              tmr_tc;

  // PC bits above the memory word address simply wrap.
  logic unused_pc_hi;
  assign unused_pc_hi = ^pc_in[31:ADDR_W];

  fetch_unit_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .clr   (clr),
    .clear (tmr_clear),
    .enable(tmr_en),
    .tc    (tmr_tc)
  );

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    pc_inc_d   = 1'b0;
    err_d      = err_q;
    tmr_clear  = 1'b0;
    tmr_en     = 1'b0;

    case (state_q)
      FETCH_IDLE: begin
        if (run) begin
          state_d = FETCH_ADDR;
        end
      end
      FETCH_ADDR: begin
        mem_addr_d = pc_in[ADDR_W-1:0];
        mem_rd_d   = 1'b1;
        tmr_clear  = 1'b1;
        state_d    = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        // Returned data takes priority over a timeout landing in the same cycle.
        if (mem_ready) begin
          ir_d       = mem_data;
          mem_rd_d   = 1'b0;
          pc_inc_d   = 1'b1;
          ir_valid_d = 1'b1;
          state_d    = FETCH_HOLD;
        end else if (tmr_tc) begin
          mem_rd_d = 1'b0;
          err_d    = 1'b1;
          state_d  = FETCH_ERR;
        end else begin
          tmr_en = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (ir_ack) begin
          ir_valid_d = 1'b0;
          state_d    = run ? FETCH_ADDR : FETCH_IDLE;
        end
      end
      FETCH_ERR: begin
        mem_rd_d   = 1'b0;
        ir_valid_d = 1'b0;
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase

    busy_d = (state_d != FETCH_IDLE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= FETCH_IDLE;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      pc_inc_q   <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      pc_inc_q   <= pc_inc_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign ir_out    = ir_q;
  assign ir_valid  = ir_valid_q;
  assign pc_inc    = pc_inc_q;
  assign fetch_err = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetches queued at issue, checked on pc_inc.
module tb_fetch_unit;

  logic        clk;
  logic        clr;
  logic        run;
  logic [31:0] pc_in;
  logic        pc_inc;
  logic [8:0]  mem_addr;
  logic        mem_rd;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic        ir_ack;
  logic        busy;
  logic        fetch_err;

  fetch_unit #(
    .ADDR_W (9),
    .TIMEOUT(16)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .run      (run),
    .pc_in    (pc_in),
    .pc_inc   (pc_inc),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_ready(mem_ready),
    .mem_data (mem_data),
    .ir_out   (ir_out),
    .ir_valid (ir_valid),
    .ir_ack   (ir_ack),
    .busy     (busy),
    .fetch_err(fetch_err)
  );

  typedef struct packed {
    logic [8:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int pc_inc_cnt  = 0;

  // memory responder / pc model controls
  logic        mem_en    = 1'b0;
  int          mem_lat   = 0;
  logic        use_fixed = 1'b0;
  logic [31:0] fixed_data = 32'h0;
  logic        pc_wired  = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory: answers a pending read after mem_lat stalled cycles.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ready = 1'b0;
    mem_data  = 32'h0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_en && mem_rd && !clr) begin
        if (wait_cnt == mem_lat) begin
          mem_ready = 1'b1;
          mem_data  = use_fixed ? fixed_data : ({23'b0, mem_addr} + 32'h1000);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // PC model: advances once per pc_inc pulse when wired in.
  initial begin
    forever begin
      @(negedge clk);
      if (pc_wired && pc_inc) pc_in = pc_in + 32'd1;
    end
  end

  // Monitor: every pc_inc must coincide with a fresh instruction matching the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pc_inc) begin
        pc_inc_cnt++;
        chk("pcinc_with_ir_valid", {31'b0, ir_valid}, 32'd1);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_unexpected: got ir_out 0x%0h with no fetch expected", ir_out);
        end else begin
          e = exp_q.pop_front();
          chk("sb_ir_out", ir_out, e.data);
          chk("sb_mem_addr", {23'b0, mem_addr}, {23'b0, e.addr});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic wait_hold(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ir_valid) break;
    end
    chk(name, {31'b0, ir_valid}, 32'd1);
  endtask

  task automatic ack_once();
    ir_ack = 1'b1;
    @(negedge clk);
    ir_ack = 1'b0;
  endtask

  initial begin
    int base;
    clr    = 1'b1;
    run    = 1'b0;
    pc_in  = 32'h0;
    ir_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_mem_addr", {23'b0, mem_addr}, 32'd0);
    chk("rst_ir_out", ir_out, 32'd0);
    clr = 1'b0;

    // Single fetch, memory answers one cycle after mem_rd
    pc_in      = 32'h10;
    mem_lat    = 1;
    use_fixed  = 1'b1;
    fixed_data = 32'hDEAD_BEEF;
    mem_en     = 1'b1;
    exp_q.push_back('{addr: 9'h010, data: 32'hDEAD_BEEF});
    run = 1'b1;
    @(negedge clk);
    chk("single_busy", {31'b0, busy}, 32'd1);
    chk("single_rd_early", {31'b0, mem_rd}, 32'd0);
    run = 1'b0;
    @(negedge clk);
    chk("single_mem_rd", {31'b0, mem_rd}, 32'd1);
    chk("single_mem_addr", {23'b0, mem_addr}, 32'h10);
    @(negedge clk);
    chk("single_valid_early", {31'b0, ir_valid}, 32'd0);
    @(negedge clk);
    chk("single_ir_valid", {31'b0, ir_valid}, 32'd1);
    chk("single_pc_inc", {31'b0, pc_inc}, 32'd1);
    chk("single_rd_drop", {31'b0, mem_rd}, 32'd0);

    // Backpressure: no ack for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ir_out", ir_out, 32'hDEAD_BEEF);
      chk("bp_mem_rd", {31'b0, mem_rd}, 32'd0);
      chk("bp_pc_inc", {31'b0, pc_inc}, 32'd0);
    end
    chk("bp_pc_inc_total", pc_inc_cnt, 32'd1);
    ack_once();
    chk("ack_ir_valid", {31'b0, ir_valid}, 32'd0);
    chk("ack_idle_busy", {31'b0, busy}, 32'd0);

    // Address wrap: upper PC bits dropped
    pc_in      = 32'h0000_0205;
    mem_lat    = 0;
    fixed_data = 32'hCAFE_F00D;
    exp_q.push_back('{addr: 9'h005, data: 32'hCAFE_F00D});
    run = 1'b1;
    wait_hold("wrap_wait");
    run = 1'b0;
    ack_once();

    // Stream with PC wired back and memory returning addr+0x1000
    @(negedge clk);
    base      = pc_inc_cnt;
    pc_in     = 32'h0;
    pc_wired  = 1'b1;
    use_fixed = 1'b0;
    exp_q.push_back('{addr: 9'h000, data: 32'h1000});
    exp_q.push_back('{addr: 9'h001, data: 32'h1001});
    exp_q.push_back('{addr: 9'h002, data: 32'h1002});
    run = 1'b1;
    for (int n = 0; n < 3; n++) begin
      wait_hold("stream_wait");
      if (n == 2) run = 1'b0;
      ack_once();
    end
    chk("stream_pc_inc_cnt", pc_inc_cnt - base, 32'd3);
    chk("stream_pc_final", pc_in, 32'd3);
    chk("stream_idle", {31'b0, busy}, 32'd0);
    pc_wired = 1'b0;

    // Data in the final timeout cycle wins over the error
    pc_in      = 32'h20;
    mem_lat    = 15;
    use_fixed  = 1'b1;
    fixed_data = 32'h1234_5678;
    exp_q.push_back('{addr: 9'h020, data: 32'h1234_5678});
    run = 1'b1;
    wait_hold("edge_wait");
    chk("edge_no_err", {31'b0, fetch_err}, 32'd0);
    run = 1'b0;
    ack_once();

    // Timeout: memory never answers
    base   = pc_inc_cnt;
    mem_en = 1'b0;
    pc_in  = 32'h30;
    run    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("to_mem_rd_rise", {31'b0, mem_rd}, 32'd1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("to_err_early", {31'b0, fetch_err}, 32'd0);
      chk("to_rd_held", {31'b0, mem_rd}, 32'd1);
    end
    @(negedge clk);
    chk("to_fetch_err", {31'b0, fetch_err}, 32'd1);
    chk("to_mem_rd", {31'b0, mem_rd}, 32'd0);
    run = 1'b0;
    repeat (5) @(negedge clk);
    chk("err_sticky", {31'b0, fetch_err}, 32'd1);
    chk("err_busy", {31'b0, busy}, 32'd1);
    chk("err_ir_valid", {31'b0, ir_valid}, 32'd0);
    chk("err_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("err_no_pc_inc", pc_inc_cnt - base, 32'd0);

    // clr exits ERR asynchronously
    #2 clr = 1'b1;
    #1;
    chk("clr_err_fetch_err", {31'b0, fetch_err}, 32'd0);
    chk("clr_err_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    clr = 1'b0;

    // clr in the middle of WAIT
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    run = 1'b0;
    chk("midwait_rd", {31'b0, mem_rd}, 32'd1);
    #2 clr = 1'b1;
    #1;
    chk("midwait_clr_rd", {31'b0, mem_rd}, 32'd0);
    chk("midwait_clr_busy", {31'b0, busy}, 32'd0);
    chk("midwait_clr_ir_out", ir_out, 32'd0);
    chk("midwait_clr_addr", {23'b0, mem_addr}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_clr_busy", {31'b0, busy}, 32'd0);
    chk("post_clr_pc_inc", pc_inc_cnt - base, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
